temp_bcd_display: RTL and testbench
===================================

# temp_bcd_display

Downstream consumer of the SPI temperature reader. Accepts each latched 8-bit two's-complement temperature sample (°C), converts it to sign plus three BCD digits with a sequential double-dabble engine, and drives a 4-digit, time-multiplexed, common-anode 7-segment display. It replaces raw nibble display of the sample with a human-readable signed decimal readout.

## Interface
- SCAN_DIV, default 4: SYSCLK cycles each digit stays selected; legal range 1..65535.
- SYSCLK  in  1  system clock; all logic is on its rising edge.
- RSTN  in  1  reset; synchronous, active-low.
- data_in  in  8  temperature sample, two's complement, -128..127 °C.
- data_valid  in  1  one-cycle strobe; data_in is valid in the same cycle.
- busy  out  1  high while a conversion is in progress; samples are dropped while high.
- bcd_valid  out  1  one-cycle pulse when the new value is loaded into the display registers.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit enables, active-low, one-hot; an[0] is units, an[1] tens, an[2] hundreds, an[3] sign.

## Operation
- FSM states:
  - IDLE: on data_valid=1, capture sign = data_in[7] and magnitude = |data_in| (8-bit unsigned; -128 gives 128), clear the iteration counter, and go to CONV.
  - CONV: perform 8 double-dabble iterations, one per cycle. Each iteration applies add-3 to every BCD nibble ≥5, then shifts {bcd[11:0], mag} left by 1. After the 8th iteration go to DONE.
  - DONE: load sign, hundreds, tens and units into the display registers, pulse bcd_valid, and return to IDLE.
- busy = (state != IDLE).
- data_valid in CONV or DONE is ignored. There is no queueing.
- Scan engine:
  - A prescaler counts 0..SCAN_DIV-1.
  - When it wraps, the 2-bit digit index advances 0→1→2→3→0.
- Digit encodings (hex, gfedcba, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F, minus=3F.
- Sign digit: minus when sign=1, blank when sign=0.
- The display registers hold the last completed value until the next DONE. A mid-conversion sample never corrupts the readout.

## Timing
- Reset values: state=IDLE, busy=0, bcd_valid=0, display registers=positive zero, prescaler=0, digit index=0, seg=7'h7F, an=4'hF.
- Conversion latency:
  - data_valid is sampled at edge N.
  - busy is high after edges N through N+9.
  - Display registers and bcd_valid update at edge N+10.
  - busy is low and bcd_valid is high in the cycle after edge N+10.
  - A new data_valid is accepted at edge N+11 at the earliest. A strobe at edge N+10 is dropped.
- Scan outputs:
  - seg and an are registered from the current digit index and display registers, so they lag the index by one cycle.
  - seg and an always change on the same edge; no cycle has mismatched seg/an.
  - After reset, an first goes active (4'b1110) one cycle after RSTN deasserts.
- Display registers change at DONE regardless of scan phase. The new digit appears on the next seg update.
- Reset mid-conversion: the FSM returns to IDLE on the next edge and the display registers return to positive zero. The partial result is discarded and bcd_valid stays 0.
- SCAN_DIV=1: the digit index advances every cycle.

## Configuration
- TEMP_DISP_BLANK_EN defined: leading-zero blanking.
  - The hundreds digit is blank when 0.
  - The tens digit is blank when hundreds and tens are both 0.
  - The units digit is never blanked.
  - The sign digit is unaffected.
- TEMP_DISP_BLANK_EN undefined: all three numeric digits always show their value, including leading zeros.

## Test plan
- Reset: hold RSTN=0 for 3 cycles, then release. Required: seg=7F, an=F, busy=0; the next cycle shows an=1110 with seg=40.
- data_in=8'h19 (+25) with data_valid:
  - busy is high for 10 cycles, then bcd_valid pulses once.
  - The scan shows units 12, tens 24, hundreds 40 (7F with BLANK_EN), sign 7F.
- data_in=8'hE7 (-25): units 12, tens 24, hundreds 40 (7F with BLANK_EN), sign 3F.
- data_in=8'h80 (-128): units 00, tens 24, hundreds 79, sign 3F. data_in=8'h7F (+127): units 78, tens 24, hundreds 79, sign 7F.
- Drop while busy: send 8'h05, then strobe 8'h63 three cycles later.
  - Exactly one bcd_valid pulse occurs and the display shows 5.
  - With BLANK_EN: units 12, tens 7F.
  - Without BLANK_EN: units 12, tens 40.
- Reset mid-conversion: send 8'h19, then assert RSTN=0 four cycles later.
  - busy=0 and bcd_valid never pulses.
  - The display registers are positive zero, and an scans through the 4 digits every 4·SCAN_DIV cycles.

Source files
------------

// File: rtl/temp_bcd_display.sv
// Signed 8-bit temperature to sign + 3-digit BCD (sequential double-dabble), shown on a
// 4-digit multiplexed common-anode 7-segment display. Define TEMP_DISP_BLANK_EN for leading-zero blanking.
module temp_bcd_display #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       SYSCLK,
    input  logic       RSTN,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       busy,
    output logic       bcd_valid,
    output logic [6:0] seg,
    output logic [3:0] an
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [3:0]  iter_cnt;
    logic [7:0]  mag;
    logic [11:0] bcd;
    logic [11:0] bcd_adj;
    logic        sign_work;

    logic        disp_sign;
    logic [3:0]  disp_hund;
    logic [3:0]  disp_tens;
    logic [3:0]  disp_units;

    logic [15:0] prescale;
    logic [1:0]  digit_idx;
    logic [6:0]  digit_seg;
    logic [3:0]  an_next;
    logic        hund_blank;
    logic        tens_blank;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_ff @(posedge SYSCLK) begin
        if (!RSTN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // CONV spends one extra cycle at iter_cnt==8 so DONE lands on the tenth edge after capture
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (data_valid) state_next = CONV;
            CONV:    if (iter_cnt == 4'd8) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (!RSTN) begin
            iter_cnt   <= '0;
            mag        <= '0;
            bcd        <= '0;
            sign_work  <= 1'b0;
            disp_sign  <= 1'b0;
            disp_hund  <= '0;
            disp_tens  <= '0;
            disp_units <= '0;
            bcd_valid  <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_valid) begin
                        sign_work <= data_in[7];
                        mag       <= data_in[7] ? (~data_in + 8'd1) : data_in;
                        bcd       <= '0;
                        iter_cnt  <= '0;
                    end
                end
                CONV: begin
                    if (iter_cnt != 4'd8) begin
                        {bcd, mag} <= {bcd_adj, mag} << 1;
                        iter_cnt   <= iter_cnt + 4'd1;
                    end
                end
                DONE: begin
                    disp_sign  <= sign_work;
                    disp_hund  <= bcd[11:8];
                    disp_tens  <= bcd[7:4];
                    disp_units <= bcd[3:0];
                    bcd_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef TEMP_DISP_BLANK_EN
    assign hund_blank = (disp_hund == 4'd0);
    assign tens_blank = hund_blank && (disp_tens == 4'd0);
`else
    assign hund_blank = 1'b0;
    assign tens_blank = 1'b0;
`endif

    always_ff @(posedge SYSCLK) begin
        if (!RSTN) begin
            prescale  <= '0;
            digit_idx <= '0;
        end else if (prescale == 16'(SCAN_DIV - 1)) begin
            prescale  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            prescale  <= prescale + 16'd1;
        end
    end

    always_comb begin
        digit_seg = 7'h7F;
        case (digit_idx)
            2'd0: digit_seg = seg_encode(disp_units);
            2'd1: digit_seg = tens_blank ? 7'h7F : seg_encode(disp_tens);
            2'd2: digit_seg = hund_blank ? 7'h7F : seg_encode(disp_hund);
            2'd3: digit_seg = disp_sign ? 7'h3F : 7'h7F;
            default: digit_seg = 7'h7F;
        endcase
    end

    assign an_next = ~(4'b0001 << digit_idx);

    // seg and an share one register stage so they always switch together
    always_ff @(posedge SYSCLK) begin
        if (!RSTN) begin
            seg <= 7'h7F;
            an  <= 4'hF;
        end else begin
            seg <= digit_seg;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_temp_bcd_display.sv
// Self-checking bench for temp_bcd_display: directed and random samples against an arithmetic decimal model.
module tb_temp_bcd_display;

    localparam int unsigned SCAN_DIV = 4;
`ifdef TEMP_DISP_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic       SYSCLK = 1'b0;
    logic       RSTN = 1'b0;
    logic [7:0] data_in = '0;
    logic       data_valid = 1'b0;
    logic       busy;
    logic       bcd_valid;
    logic [6:0] seg;
    logic [3:0] an;

    int tests = 0;
    int fails = 0;

    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 SYSCLK = ~SYSCLK;

    temp_bcd_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .SYSCLK    (SYSCLK),
        .RSTN      (RSTN),
        .data_in   (data_in),
        .data_valid(data_valid),
        .busy      (busy),
        .bcd_valid (bcd_valid),
        .seg       (seg),
        .an        (an)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge SYSCLK);
        #1;
    endtask

    // Expected pattern for digit position pos (0 units .. 3 sign) showing sample v
    function automatic logic [6:0] exp_seg(input int pos, input logic [7:0] v);
        int val, m, h, t, u;
        val = int'($signed(v));
        m   = (val < 0) ? -val : val;
        h   = m / 100;
        t   = (m / 10) % 10;
        u   = m % 10;
        case (pos)
            0:       return seg_tbl[u];
            1:       return (BLANK && h == 0 && t == 0) ? 7'h7F : seg_tbl[t];
            2:       return (BLANK && h == 0) ? 7'h7F : seg_tbl[h];
            default: return (val < 0) ? 7'h3F : 7'h7F;
        endcase
    endfunction

    task automatic check_display(input logic [7:0] v, input string tag);
        logic [6:0] seen [4];
        int bad;
        bad = 0;
        for (int i = 0; i < 4; i++) seen[i] = 'x;
        for (int c = 0; c < int'(4 * SCAN_DIV) + 1; c++) begin
            case (an)
                4'b1110: seen[0] = seg;
                4'b1101: seen[1] = seg;
                4'b1011: seen[2] = seg;
                4'b0111: seen[3] = seg;
                default: bad++;
            endcase
            step();
        end
        chk({tag, "_an_onehot"}, 16'(bad), 16'd0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_digit%0d", tag, i), {9'd0, seen[i]}, {9'd0, exp_seg(i, v)});
    endtask

    task automatic run_conv(input logic [7:0] v, input string tag);
        int  busy_cnt;
        bit  early;
        busy_cnt = 0;
        early    = 1'b0;
        data_in    = v;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (busy) busy_cnt++;
            if (bcd_valid) early = 1'b1;
            step();
        end
        chk({tag, "_busy_cycles"}, 16'(busy_cnt), 16'd10);
        chk({tag, "_early_valid"}, {15'd0, early}, 16'd0);
        chk({tag, "_busy_end"}, {15'd0, busy}, 16'd0);
        chk({tag, "_valid_pulse"}, {15'd0, bcd_valid}, 16'd1);
        step();
        chk({tag, "_valid_once"}, {15'd0, bcd_valid}, 16'd0);
        check_display(v, tag);
    endtask

    initial begin
        int pulses, busy_hi, t_first, t_second;
        logic [3:0] prev_an;
        logic [7:0] rv;

        // Reset
        RSTN = 1'b0;
        step(); step(); step();
        chk("rst_seg", {9'd0, seg}, 16'h7F);
        chk("rst_an", {12'd0, an}, 16'hF);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_valid", {15'd0, bcd_valid}, 16'd0);
        RSTN = 1'b1;
        step();
        chk("rel_an", {12'd0, an}, 16'hE);
        chk("rel_seg", {9'd0, seg}, 16'h40);
        check_display(8'h00, "zero_after_rst");

        // Directed values
        run_conv(8'h19, "p25");
        run_conv(8'hE7, "m25");
        run_conv(8'h80, "m128");
        run_conv(8'h7F, "p127");
        run_conv(8'h64, "p100");
        run_conv(8'h00, "p0");
        run_conv(8'hFF, "m1");

        // Strobe during CONV is dropped
        data_in = 8'h05; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        step(); step();
        data_in = 8'h63; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (bcd_valid) pulses++;
            step();
        end
        chk("drop_pulses", 16'(pulses), 16'd1);
        check_display(8'h05, "drop");

        // Strobe on the DONE edge is dropped; the next edge accepts
        data_in = 8'h2A; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        for (int k = 0; k < 9; k++) step();
        data_in = 8'h11; data_valid = 1'b1;
        step();
        chk("edge10_busy", {15'd0, busy}, 16'd0);
        chk("edge10_valid", {15'd0, bcd_valid}, 16'd1);
        step();
        data_valid = 1'b0;
        chk("edge11_accept", {15'd0, busy}, 16'd1);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (bcd_valid) pulses++;
            step();
        end
        chk("edge11_pulses", 16'(pulses), 16'd1);
        step();
        check_display(8'h11, "edge11");

        // Random samples
        for (int r = 0; r < 10; r++) begin
            rv = 8'($urandom_range(0, 255));
            run_conv(rv, $sformatf("rnd%0d_%02h", r, rv));
        end

        // Reset mid-conversion
        data_in = 8'h19; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        step(); step(); step();
        RSTN = 1'b0;
        step();
        chk("midrst_busy", {15'd0, busy}, 16'd0);
        chk("midrst_valid", {15'd0, bcd_valid}, 16'd0);
        chk("midrst_seg", {9'd0, seg}, 16'h7F);
        chk("midrst_an", {12'd0, an}, 16'hF);
        step();
        RSTN = 1'b1;
        step();
        chk("midrst_rel_an", {12'd0, an}, 16'hE);
        pulses  = 0;
        busy_hi = 0;
        for (int k = 0; k < 20; k++) begin
            if (bcd_valid) pulses++;
            if (busy) busy_hi++;
            step();
        end
        chk("midrst_no_pulse", 16'(pulses), 16'd0);
        chk("midrst_no_busy", 16'(busy_hi), 16'd0);
        check_display(8'h00, "midrst");

        // Scan period
        t_first  = -1;
        t_second = -1;
        prev_an  = an;
        for (int c = 0; c < int'(12 * SCAN_DIV); c++) begin
            step();
            if (an == 4'b1110 && prev_an != 4'b1110) begin
                if (t_first < 0) t_first = c;
                else if (t_second < 0) t_second = c;
            end
            prev_an = an;
        end
        chk("scan_period", 16'(t_second - t_first), 16'(4 * SCAN_DIV));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
